security_lock_fsm: RTL and testbench
====================================

// Module: security_lock_fsm
// PURPOSE
//  Parametrised code-entry lock controller for the security system. It accepts single-cycle
//  digit pulses from the debounced keypad front end and compares a CODE_LEN-digit entry
//  against a fixed code. It counts failed attempts and enforces a timed lockout after
//  MAX_ATTEMPTS failures. Partial entries are discarded on inactivity. Outputs drive the
//  status LEDs and the system status bus.
// PARAMETERS
//  DIGIT_W        4        bits per keypad digit
//  CODE_LEN       4        digits per code entry (>=1)
//  CODE           16'h1234 expected code, CODE_LEN*DIGIT_W bits; first digit entered = MS digit
//  MAX_ATTEMPTS   3        consecutive failures before lockout (>=1)
//  LOCKOUT_CYCLES 1000     lockout duration in i_Clk cycles (>=2)
//  TIMEOUT_CYCLES 500      idle cycles allowed between digits mid-entry (>=2)
// PORTS
//  i_Clk          in   1                   system clock, all logic on rising edge
//  i_Reset        in   1                   synchronous, active-high reset
//  i_Digit_Valid  in   1                   one-cycle pulse: i_Digit is valid this cycle
//  i_Digit        in   DIGIT_W             digit value
//  i_Arm          in   1                   one-cycle pulse: re-arm from DISARMED
//  o_LED_1        out  1                   1 while DISARMED
//  o_LED_2        out  1                   1 while fail count > 0 or in LOCKOUT
//  o_Locked       out  1                   1 while in LOCKOUT
//  o_Fail_Count   out  $clog2(MAX_ATTEMPTS+1)  consecutive failed attempts
//  o_State        out  3                   ARMED=0, ENTRY=1, CHECK=2, DISARMED=3, LOCKOUT=4
// BEHAVIOUR
//  - All outputs are registered or decoded from registered state only.
//  - Reset (sync, any state, mid-entry included): state=ARMED; digit count, fail count,
//    timers and entry shift register cleared; every output 0.
//  - ARMED: a digit pulse shifts the digit into the entry register, sets count=1 and
//    goes to ENTRY. If CODE_LEN==1, it goes directly to CHECK. i_Arm is ignored.
//  - ENTRY: each digit pulse shifts in and increments the count. The pulse that makes
//    count==CODE_LEN moves to CHECK on the next edge.
//  - ENTRY timeout: the idle timer resets on each accepted digit. After TIMEOUT_CYCLES
//    cycles with no digit, return to ARMED, discard the partial entry and leave fail
//    count unchanged. A digit arriving on the expiry cycle wins: it is accepted and
//    the timer restarts.
//  - CHECK: lasts one cycle; digits are ignored. The full entry is compared to CODE with
//    no early abort on the first wrong digit.
//    Match: go to DISARMED, fail count cleared.
//    Mismatch: fail count +1; if the new count == MAX_ATTEMPTS go to LOCKOUT, else ARMED.
//  - Latency: last digit pulse at edge N -> o_State=CHECK after N -> result state after N+1.
//  - DISARMED: digits ignored. An i_Arm pulse moves to ARMED.
//  - LOCKOUT: digits and i_Arm ignored. Stays exactly LOCKOUT_CYCLES cycles, then goes to
//    ARMED with fail count cleared (o_LED_2 drops in the same cycle).
//  - Fail count saturates at MAX_ATTEMPTS and never wraps. A lockout timer that reaches
//    terminal count resets to 0.
//  - Unreachable encodings of o_State (5..7) recover to ARMED on the next edge, with
//    counts cleared.
// TESTING (bench params: CODE=16'h1234, CODE_LEN=4, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=20,
//          TIMEOUT_CYCLES=10)
//  1 Reset, then digits 1,2,3,4 on consecutive cycles -> CHECK for 1 cycle, then DISARMED,
//    o_LED_1=1, o_Fail_Count=0; i_Arm pulse -> ARMED, o_LED_1=0.
//  2 Enter 1,2,3,5 -> ARMED, o_Fail_Count=1, o_LED_2=1; then 1,2,3,4 -> DISARMED,
//    o_Fail_Count=0, o_LED_2=0.
//  3 Three wrong entries -> LOCKOUT, o_Locked=1 for exactly 20 cycles; digits 1,2,3,4
//    inside lockout are ignored; on exit ARMED, o_Fail_Count=0, o_Locked=0.
//  4 Enter 1,2 then idle 10 cycles -> ARMED, count discarded, o_Fail_Count unchanged;
//    a digit on the 10th idle cycle -> stays ENTRY with count=3.
//  5 Assert i_Reset mid-entry (after 1,2) and in LOCKOUT -> next edge ARMED, all
//    outputs 0; a following 1,2,3,4 -> DISARMED.
//  6 In DISARMED, i_Arm and a digit pulse in the same cycle -> ARMED with count=0
//    (digit dropped).

Source files
------------

// File: rtl/security_lock_fsm.sv
// security_lock_fsm: keypad code-entry lock with failed-attempt counting,
// timed lockout and inactivity discard of partial entries.
`default_nettype none

module security_lock_fsm #(
   parameter int DIGIT_W        = 4,
   parameter int CODE_LEN       = 4,
   parameter logic [CODE_LEN*DIGIT_W-1:0] CODE = 16'h1234,
   parameter int MAX_ATTEMPTS   = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int TIMEOUT_CYCLES = 500
) (
   input  logic                              i_Clk,
   input  logic                              i_Reset,
   input  logic                              i_Digit_Valid,
   input  logic [DIGIT_W-1:0]                i_Digit,
   input  logic                              i_Arm,
   output logic                              o_LED_1,
   output logic                              o_LED_2,
   output logic                              o_Locked,
   output logic [$clog2(MAX_ATTEMPTS+1)-1:0] o_Fail_Count,
   output logic [2:0]                        o_State
);

   localparam int CODE_W = CODE_LEN * DIGIT_W;
   localparam int CNT_W  = $clog2(CODE_LEN + 1);
   localparam int FAIL_W = $clog2(MAX_ATTEMPTS + 1);
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
   localparam int LOCK_W = $clog2(LOCKOUT_CYCLES);

   localparam logic [CNT_W-1:0]  LEN_LAST  = CNT_W'(CODE_LEN - 1);
   localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_ATTEMPTS - 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_ATTEMPTS);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ARMED    = 3'd0,
      ENTRY    = 3'd1,
      CHECK    = 3'd2,
      DISARMED = 3'd3,
      LOCKOUT  = 3'd4
   } state_t;

   state_t              state, state_next;
   logic [CODE_W-1:0]   entry, entry_next, shifted;
   logic [CNT_W-1:0]    count, count_next;
   logic [FAIL_W-1:0]   fail, fail_next;
   logic [IDLE_W-1:0]   idle, idle_next;
   logic [LOCK_W-1:0]   lock, lock_next;

   // First digit entered ends up in the most significant position.
   assign shifted = (entry << DIGIT_W) | CODE_W'(i_Digit);

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state <= ARMED;
         entry <= '0;
         count <= '0;
         fail  <= '0;
         idle  <= '0;
         lock  <= '0;
      end else begin
         state <= state_next;
         entry <= entry_next;
         count <= count_next;
         fail  <= fail_next;
         idle  <= idle_next;
         lock  <= lock_next;
      end
   end

   always_comb begin
      state_next = state;
      entry_next = entry;
      count_next = count;
      fail_next  = fail;
      idle_next  = idle;
      lock_next  = lock;
      case (state)
         ARMED: begin
            if (i_Digit_Valid) begin
               entry_next = shifted;
               count_next = CNT_W'(1);
               idle_next  = '0;
               state_next = (CODE_LEN == 1) ? CHECK : ENTRY;
            end
         end
         ENTRY: begin
            // A digit on the expiry cycle takes priority over the timeout.
            if (i_Digit_Valid) begin
               entry_next = shifted;
               count_next = count + CNT_W'(1);
               idle_next  = '0;
               if (count == LEN_LAST) state_next = CHECK;
            end else if (idle == IDLE_LAST) begin
               entry_next = '0;
               count_next = '0;
               idle_next  = '0;
               state_next = ARMED;
            end else begin
               idle_next = idle + IDLE_W'(1);
            end
         end
         CHECK: begin
            entry_next = '0;
            count_next = '0;
            idle_next  = '0;
            if (entry == CODE) begin
               fail_next  = '0;
               state_next = DISARMED;
            end else if (fail >= FAIL_LAST) begin
               fail_next  = FAIL_MAX;
               lock_next  = '0;
               state_next = LOCKOUT;
            end else begin
               fail_next  = fail + FAIL_W'(1);
               state_next = ARMED;
            end
         end
         DISARMED: begin
            if (i_Arm) state_next = ARMED;
         end
         LOCKOUT: begin
            if (lock == LOCK_LAST) begin
               lock_next  = '0;
               fail_next  = '0;
               state_next = ARMED;
            end else begin
               lock_next = lock + LOCK_W'(1);
            end
         end
         default: begin
            state_next = ARMED;
            entry_next = '0;
            count_next = '0;
            fail_next  = '0;
            idle_next  = '0;
            lock_next  = '0;
         end
      endcase
   end

   assign o_State      = state;
   assign o_LED_1      = (state == DISARMED);
   assign o_Locked     = (state == LOCKOUT);
   assign o_LED_2      = (fail != '0) || (state == LOCKOUT);
   assign o_Fail_Count = fail;

endmodule

`default_nettype wire

// File: tb/tb_security_lock_fsm.sv
// tb_security_lock_fsm: directed scenarios plus random traffic checked
// every cycle against a queue-based behavioural model of the lock.
`default_nettype none

module tb_security_lock_fsm;

   localparam int DIGIT_W  = 4;
   localparam int CODE_LEN = 4;
   localparam int CODE     = 'h1234;
   localparam int MAX_ATT  = 3;
   localparam int LOCK_CYC = 20;
   localparam int TOUT_CYC = 10;

   localparam int S_ARMED = 0, S_ENTRY = 1, S_CHECK = 2, S_DISARMED = 3, S_LOCKOUT = 4;

   logic                i_Clk = 1'b0;
   logic                i_Reset = 1'b0;
   logic                i_Digit_Valid = 1'b0;
   logic [DIGIT_W-1:0]  i_Digit = '0;
   logic                i_Arm = 1'b0;
   logic                o_LED_1, o_LED_2, o_Locked;
   logic [1:0]          o_Fail_Count;
   logic [2:0]          o_State;

   int n_checks = 0;
   int n_pass   = 0;

   security_lock_fsm #(
      .DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN), .CODE(16'h1234),
      .MAX_ATTEMPTS(MAX_ATT), .LOCKOUT_CYCLES(LOCK_CYC), .TIMEOUT_CYCLES(TOUT_CYC)
   ) dut (
      .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Digit_Valid(i_Digit_Valid),
      .i_Digit(i_Digit), .i_Arm(i_Arm), .o_LED_1(o_LED_1), .o_LED_2(o_LED_2),
      .o_Locked(o_Locked), .o_Fail_Count(o_Fail_Count), .o_State(o_State)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: digits held in a queue, timers count down to expiry.
   int m_state = S_ARMED;
   int m_q[$];
   int m_fail = 0;
   int m_idle_left = 0;
   int m_lock_left = 0;

   function automatic int entry_value();
      int v = 0;
      foreach (m_q[k]) v = v * (1 << DIGIT_W) + m_q[k];
      return v;
   endfunction

   task automatic model_step(input bit v, input int d, input bit a, input bit r);
      if (r) begin
         m_state = S_ARMED; m_q.delete(); m_fail = 0; m_idle_left = 0; m_lock_left = 0;
         return;
      end
      case (m_state)
         S_ARMED: if (v) begin
            m_q.delete(); m_q.push_back(d); m_idle_left = TOUT_CYC;
            m_state = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
         end
         S_ENTRY: if (v) begin
            m_q.push_back(d); m_idle_left = TOUT_CYC;
            if (m_q.size() == CODE_LEN) m_state = S_CHECK;
         end else begin
            m_idle_left--;
            if (m_idle_left == 0) begin m_q.delete(); m_state = S_ARMED; end
         end
         S_CHECK: begin
            if (entry_value() == CODE) begin
               m_fail = 0; m_state = S_DISARMED;
            end else begin
               m_fail++;
               if (m_fail >= MAX_ATT) begin
                  m_fail = MAX_ATT; m_lock_left = LOCK_CYC; m_state = S_LOCKOUT;
               end else m_state = S_ARMED;
            end
            m_q.delete();
         end
         S_DISARMED: if (a) m_state = S_ARMED;
         S_LOCKOUT: begin
            m_lock_left--;
            if (m_lock_left == 0) begin m_fail = 0; m_state = S_ARMED; end
         end
         default: m_state = S_ARMED;
      endcase
   endtask

   task automatic compare_all();
      check_eq("state",  32'(o_State),      32'(m_state));
      check_eq("led1",   32'(o_LED_1),      32'(m_state == S_DISARMED));
      check_eq("led2",   32'(o_LED_2),      32'(m_fail > 0 || m_state == S_LOCKOUT));
      check_eq("locked", 32'(o_Locked),     32'(m_state == S_LOCKOUT));
      check_eq("fails",  32'(o_Fail_Count), 32'(m_fail));
   endtask

   // One clock: drive, let the edge happen, advance the model, compare.
   task automatic cyc(input bit v, input int d, input bit a, input bit r);
      i_Digit_Valid = v; i_Digit = DIGIT_W'(d); i_Arm = a; i_Reset = r;
      @(posedge i_Clk);
      model_step(v, d, a, r);
      #1;
      compare_all();
      i_Digit_Valid = 1'b0; i_Arm = 1'b0; i_Reset = 1'b0;
   endtask

   task automatic enter(input int code);
      for (int k = CODE_LEN - 1; k >= 0; k--) cyc(1'b1, (code >> (DIGIT_W * k)) & 'hF, 1'b0, 1'b0);
   endtask

   initial begin
      #1;
      cyc(0, 0, 0, 1);
      check_eq("reset_state", 32'(o_State), 32'(S_ARMED));
      check_eq("reset_led2", 32'(o_LED_2), 32'd0);

      // Correct code, CHECK for one cycle, then DISARMED; arm again.
      enter('h1234);
      check_eq("t1_check", 32'(o_State), 32'(S_CHECK));
      cyc(0, 0, 0, 0);
      check_eq("t1_disarmed", 32'(o_State), 32'(S_DISARMED));
      check_eq("t1_led1", 32'(o_LED_1), 32'd1);
      cyc(0, 0, 1, 0);
      check_eq("t1_rearm", 32'(o_State), 32'(S_ARMED));

      // One wrong attempt, then a right one clears the count.
      enter('h1235); cyc(0, 0, 0, 0);
      check_eq("t2_fail1", 32'(o_Fail_Count), 32'd1);
      enter('h1234); cyc(0, 0, 0, 0);
      check_eq("t2_clear", 32'(o_Fail_Count), 32'd0);
      cyc(0, 0, 1, 0);

      // Three wrong attempts -> lockout lasting exactly LOCK_CYC cycles.
      for (int a = 0; a < MAX_ATT; a++) begin enter('h9999); cyc(0, 0, 0, 0); end
      begin
         int lock_len = 1;
         check_eq("t3_locked", 32'(o_Locked), 32'd1);
         for (int c = 0; c < LOCK_CYC + 4; c++) begin
            cyc(c < 4, (c + 1) & 'hF, c == 5, 0);
            if (o_Locked) lock_len++;
         end
         check_eq("t3_lock_len", 32'(lock_len), 32'(LOCK_CYC));
         check_eq("t3_exit", 32'(o_State), 32'(S_ARMED));
      end

      // Inactivity timeout, then a digit on the final idle cycle.
      enter('h1235); cyc(0, 0, 0, 0);
      cyc(1, 1, 0, 0); cyc(1, 2, 0, 0);
      for (int c = 0; c < TOUT_CYC; c++) cyc(0, 0, 0, 0);
      check_eq("t4_timeout", 32'(o_State), 32'(S_ARMED));
      check_eq("t4_fails", 32'(o_Fail_Count), 32'd1);
      cyc(1, 1, 0, 0); cyc(1, 2, 0, 0);
      for (int c = 0; c < TOUT_CYC - 1; c++) cyc(0, 0, 0, 0);
      cyc(1, 3, 0, 0);
      check_eq("t4_late_digit", 32'(o_State), 32'(S_ENTRY));
      cyc(1, 4, 0, 0);
      check_eq("t4_fourth", 32'(o_State), 32'(S_CHECK));
      cyc(0, 0, 0, 0);

      // Reset mid-entry and during lockout.
      cyc(0, 0, 1, 0);
      cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(0, 0, 0, 1);
      check_eq("t5_rst_entry", 32'(o_State), 32'(S_ARMED));
      for (int a = 0; a < MAX_ATT; a++) begin enter('h4321); cyc(0, 0, 0, 0); end
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);
      check_eq("t5_rst_lock", 32'(o_Locked), 32'd0);
      check_eq("t5_rst_fails", 32'(o_Fail_Count), 32'd0);
      enter('h1234); cyc(0, 0, 0, 0);
      check_eq("t5_disarm", 32'(o_State), 32'(S_DISARMED));

      // Arm and digit together in DISARMED: digit dropped.
      cyc(1, 1, 1, 0);
      check_eq("t6_armed", 32'(o_State), 32'(S_ARMED));
      cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 0, 0);
      check_eq("t6_count3", 32'(o_State), 32'(S_ENTRY));
      for (int c = 0; c < TOUT_CYC; c++) cyc(0, 0, 0, 0);

      // Random traffic biased toward the correct code, with quiet stretches.
      begin
         bit quiet = 1'b0;
         for (int n = 0; n < 4000; n++) begin
            int idx, nxt, d;
            bit v, a, r;
            if ($urandom_range(0, 19) == 0) quiet = ~quiet;
            idx = m_q.size();
            nxt = (idx < CODE_LEN) ? (CODE >> (DIGIT_W * (CODE_LEN - 1 - idx))) & 'hF : 0;
            d = ($urandom_range(0, 3) != 0) ? nxt : int'($urandom_range(0, 15));
            v = quiet ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) != 0);
            a = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 299) == 0);
            cyc(v, d, a, r);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

`default_nettype wire
